// File: rtl/golden_nonce_queue.sv
// golden_nonce_queue: captures distinct golden nonces from hashcore into a
// small FIFO and hands them out one per host snapshot request as a 96-bit
// word {status, nonce, golden}. A data_change pulse flushes everything so
// results found on old work are never reported against new work.
//
// Handshake: there is no valid/ready pair. gn_match is a level that is
// deduplicated against the last seen nonce, and snap is a one-cycle request
// that is always serviced. out_word updates on the cycle after snap and
// holds otherwise. If the FIFO has no free slot after this cycle's pop, the
// incoming nonce is dropped and counted in overflow_cnt.
module golden_nonce_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gn_match,
  input  logic [31:0]   golden_nonce,
  input  logic [31:0]   nonce,
  input  logic          data_change,
  input  logic          snap,
  output logic [95:0]   out_word,
  output logic [AW:0]   level
);

  localparam int LW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic [7:0]    overflow_cnt;
  logic          last_valid;
  logic [31:0]   last_seen;

  logic          candidate;
  logic          do_pop;
  logic          do_push;
  logic          do_drop;
  logic [LW-1:0] lvl_after_pop;
  logic [LW-1:0] lvl_next;
  logic [7:0]    ovf_next;
  logic [31:0]   status;

  // Decide this cycle's pop/push/drop; the pop frees a slot before the push.
  always_comb begin
    candidate     = gn_match && (!last_valid || (golden_nonce != last_seen));
    do_pop        = snap && (cnt != '0);
    lvl_after_pop = cnt - LW'(do_pop);
    do_push       = candidate && (lvl_after_pop != LW'(DEPTH));
    do_drop       = candidate && !do_push;
    lvl_next      = lvl_after_pop + LW'(do_push);
    ovf_next      = overflow_cnt;
    if (do_drop && (overflow_cnt != 8'hFF)) begin
      ovf_next = overflow_cnt + 8'd1;
    end
    status = {ovf_next, 8'(lvl_next), 15'h0, do_pop};
  end

  // Entry storage: plain synchronous write, no reset needed on the data.
  always_ff @(posedge clk) begin
    if (!reset && !data_change && do_push) begin
      mem[wr_ptr] <= golden_nonce;
    end
  end

  // Control state, dedup tracking and the snapshot output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      overflow_cnt <= 8'h0;
      last_valid   <= 1'b0;
      last_seen    <= 32'h0;
      out_word     <= 96'h0;
    end else if (data_change) begin
      // Flush wins over push and pop; a coincident snap still reports empty.
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      overflow_cnt <= 8'h0;
      last_valid   <= 1'b0;
      if (snap) begin
        out_word <= {32'h0, nonce, 32'h0};
      end
    end else begin
      if (candidate) begin
        last_seen  <= golden_nonce;
        last_valid <= 1'b1;
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt          <= lvl_next;
      overflow_cnt <= ovf_next;
      if (snap) begin
        out_word <= {status, nonce, (do_pop ? mem[rd_ptr] : 32'h0)};
      end
    end
  end

  assign level = cnt;

endmodule
